// File: rtl/prbs_link_ctrl.sv
// prbs_link_ctrl: GT reset sequencing, PRBS error qualification and link-up
// declaration with bounded retry for the multi-lane PRBS test path.
module prbs_link_ctrl #(
  parameter int unsigned NUMBER_OF_LANES     = 2,
  parameter int unsigned RESET_HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned CHECK_WINDOW_CYCLES = 1024,
  parameter int unsigned ERR_THRESH          = 0,
  parameter int unsigned MAX_RETRY           = 3
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_rst_n_i,
  input  logic                       enable_i,
  input  logic [NUMBER_OF_LANES-1:0] gt_tx_reset_done_i,
  input  logic [NUMBER_OF_LANES-1:0] gt_rx_reset_done_i,
  input  logic [NUMBER_OF_LANES-1:0] prbs_err_i,
  output logic                       gt_reset_o,
  output logic                       link_up_o,
  output logic                       fail_o,
  output logic [2:0]                 state_o,
  output logic [15:0]                err_cnt_o,
  output logic [3:0]                 retry_cnt_o
);

  localparam int unsigned MAX_HW =
    (RESET_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ? RESET_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CYC =
    (MAX_HW > CHECK_WINDOW_CYCLES) ? MAX_HW : CHECK_WINDOW_CYCLES;
  localparam int unsigned TW = $clog2(MAX_CYC + 1);
  localparam int unsigned CW = $clog2(NUMBER_OF_LANES + 1);

  localparam logic [TW-1:0] HOLD_LAST = TW'(RESET_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] WIN_LAST  = TW'(CHECK_WINDOW_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_CHECK     = 3'd3,
    ST_UP        = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic          all_done;
  logic          retry_req;
  logic          retry_last;
  logic [CW-1:0] err_pop;
  logic [16:0]   err_sum;
  logic [15:0]   err_sat;

  assign all_done   = (&gt_tx_reset_done_i) & (&gt_rx_reset_done_i);
  assign retry_last = (retry_cnt_o + 4'd1) == RETRY_MAX;
  assign err_sum    = {1'b0, err_cnt_o} + 17'(err_pop);
  assign err_sat    = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  assign state_o    = state;

  // Number of lanes flagging a PRBS error this cycle
  always_comb begin
    err_pop = '0;
    for (int i = 0; i < int'(NUMBER_OF_LANES); i++) begin
      err_pop = err_pop + CW'(prbs_err_i[i]);
    end
  end

  // Next-state decision; disable overrides everything, retries fold into RESET/FAIL
  always_comb begin
    state_nxt = state;
    retry_req = 1'b0;
    if (!enable_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_RESET;
        ST_RESET: begin
          if (timer == HOLD_LAST) state_nxt = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (all_done)               state_nxt = ST_CHECK;
          else if (timer == LOCK_LAST) retry_req = 1'b1;
        end
        ST_CHECK: begin
          if (!all_done) begin
            retry_req = 1'b1;
          end else if (timer == WIN_LAST) begin
            if (32'(err_sat) <= ERR_THRESH) state_nxt = ST_UP;
            else                            retry_req = 1'b1;
          end
        end
        ST_UP: begin
          if ((|prbs_err_i) || !all_done) retry_req = 1'b1;
        end
        ST_FAIL: state_nxt = ST_FAIL;
        default: state_nxt = ST_IDLE;
      endcase
      if (retry_req) state_nxt = retry_last ? ST_FAIL : ST_RESET;
    end
  end

  // FSM register, shared timer, counters and Moore outputs decoded from the next state
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state       <= ST_IDLE;
      timer       <= '0;
      gt_reset_o  <= 1'b1;
      link_up_o   <= 1'b0;
      fail_o      <= 1'b0;
      err_cnt_o   <= '0;
      retry_cnt_o <= '0;
    end else begin
      state      <= state_nxt;
      gt_reset_o <= (state_nxt == ST_IDLE) || (state_nxt == ST_RESET) ||
                    (state_nxt == ST_FAIL);
      link_up_o  <= (state_nxt == ST_UP);
      fail_o     <= (state_nxt == ST_FAIL);

      // timer only runs in the timed states, so it never wraps while parked
      if (state_nxt != state) begin
        timer <= '0;
      end else if ((state == ST_RESET) || (state == ST_WAIT_DONE) ||
                   (state == ST_CHECK)) begin
        timer <= timer + TW'(1);
      end

      if (!enable_i || (state == ST_IDLE)) begin
        retry_cnt_o <= '0;
      end else if (retry_req) begin
        retry_cnt_o <= retry_last ? RETRY_MAX : retry_cnt_o + 4'd1;
      end

      // a disabling edge neither clears nor accumulates the error count
      if (enable_i) begin
        if ((state == ST_WAIT_DONE) && all_done) begin
          err_cnt_o <= '0;
        end else if ((state == ST_CHECK) || (state == ST_UP)) begin
          err_cnt_o <= err_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs_link_ctrl.sv
// tb_prbs_link_ctrl: directed and randomized checks of prbs_link_ctrl against
// a cycle-level behavioural model, plus a long-window saturation instance.
module tb_prbs_link_ctrl;

  localparam int unsigned NL   = 2;
  localparam int unsigned HOLD = 4;
  localparam int unsigned LOCK = 20;
  localparam int unsigned WIN  = 8;
  localparam int unsigned TH   = 1;
  localparam int unsigned MAXR = 2;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [NL-1:0] tx, rx, perr;
  logic          gt_reset, link_up, fail;
  logic [2:0]    st;
  logic [15:0]   err;
  logic [3:0]    retry;

  logic          sat_en;
  logic [NL-1:0] sat_done, sat_err;
  logic          sat_gt_reset, sat_link_up, sat_fail;
  logic [2:0]    sat_st;
  logic [15:0]   sat_cnt;
  logic [3:0]    sat_retry;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model: state code, cycles spent in state, error count, retries
  int m_state, m_cyc, m_err, m_retry;

  prbs_link_ctrl #(
    .NUMBER_OF_LANES(NL), .RESET_HOLD_CYCLES(HOLD), .LOCK_TIMEOUT_CYCLES(LOCK),
    .CHECK_WINDOW_CYCLES(WIN), .ERR_THRESH(TH), .MAX_RETRY(MAXR)
  ) dut (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .enable_i(en),
    .gt_tx_reset_done_i(tx), .gt_rx_reset_done_i(rx), .prbs_err_i(perr),
    .gt_reset_o(gt_reset), .link_up_o(link_up), .fail_o(fail),
    .state_o(st), .err_cnt_o(err), .retry_cnt_o(retry)
  );

  prbs_link_ctrl #(
    .NUMBER_OF_LANES(NL), .RESET_HOLD_CYCLES(HOLD), .LOCK_TIMEOUT_CYCLES(LOCK),
    .CHECK_WINDOW_CYCLES(40000), .ERR_THRESH(32'hFFFF), .MAX_RETRY(MAXR)
  ) dut_sat (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .enable_i(sat_en),
    .gt_tx_reset_done_i(sat_done), .gt_rx_reset_done_i(sat_done), .prbs_err_i(sat_err),
    .gt_reset_o(sat_gt_reset), .link_up_o(sat_link_up), .fail_o(sat_fail),
    .state_o(sat_st), .err_cnt_o(sat_cnt), .retry_cnt_o(sat_retry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic m_enter(input int s);
    m_state = s;
    m_cyc   = 0;
  endtask

  task automatic m_retry_act();
    if (m_retry + 1 == int'(MAXR)) begin
      m_retry = MAXR;
      m_enter(5);
    end else begin
      m_retry++;
      m_enter(1);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cyc = 0; m_err = 0; m_retry = 0;
  endtask

  // one clock edge of the link controller as described by its rules
  task automatic model_step();
    bit ad;
    int pop;
    ad  = (&tx) && (&rx);
    pop = $countones(perr);
    if (!en) begin
      m_enter(0);
      m_retry = 0;
    end else begin
      case (m_state)
        0: m_enter(1);
        1: begin
          m_cyc++;
          if (m_cyc == int'(HOLD)) m_enter(2);
        end
        2: begin
          m_cyc++;
          if (ad) begin
            m_err = 0;
            m_enter(3);
          end else if (m_cyc == int'(LOCK)) m_retry_act();
        end
        3: begin
          m_cyc++;
          m_err = sat16(m_err + pop);
          if (!ad) m_retry_act();
          else if (m_cyc == int'(WIN)) begin
            if (m_err <= int'(TH)) m_enter(4);
            else m_retry_act();
          end
        end
        4: begin
          m_err = sat16(m_err + pop);
          if (pop != 0 || !ad) m_retry_act();
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check("state",    32'(st),       32'(m_state));
    check("gt_reset", 32'(gt_reset), 32'(m_state == 0 || m_state == 1 || m_state == 5));
    check("link_up",  32'(link_up),  32'(m_state == 4));
    check("fail",     32'(fail),     32'(m_state == 5));
    check("err_cnt",  32'(err),      32'(m_err));
    check("retry",    32'(retry),    32'(m_retry));
  endtask

  // one clock: model follows the sampled inputs, outputs checked 1 ns later
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    perr = '0;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (st != target && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 32'(st), 32'(target));
  endtask

  task automatic restart();
    en = 1'b0;
    cycle();
    en = 1'b1;
  endtask

  task automatic sat_wait(input logic [2:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (sat_st != target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(sat_st), 32'(target));
  endtask

  initial begin
    int rst_cnt, c3, cu, n2, mode;
    rst_n = 1'b0; en = 1'b0; tx = '0; rx = '0; perr = '0;
    sat_en = 1'b0; sat_done = 2'b11; sat_err = '0;
    model_reset();
    #12;
    compare_all();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // clean bring-up, done buses high from the sixth cycle
    en = 1'b1; rst_cnt = 0; c3 = -1; cu = -1;
    for (int i = 0; i < 40; i++) begin
      tx = (i >= 5) ? 2'b11 : 2'b00;
      rx = tx;
      cycle();
      if (st == 3'd1 && gt_reset) rst_cnt++;
      if (st == 3'd3 && c3 < 0) c3 = i;
      if (link_up) begin
        cu = i;
        break;
      end
    end
    check("rst_hold", 32'(rst_cnt), 32'(HOLD));
    check("up_lat", 32'(cu - c3), 32'(WIN));
    check("clean_err", 32'(err), 32'd0);

    // one error in the window is tolerated, two are not
    restart();
    wait_state(3'd3, 20, "thr1_chk");
    perr = 2'b01;
    cycle();
    wait_state(3'd4, 20, "thr1_up");
    check("thr1_err", 32'(err), 32'd1);
    restart();
    wait_state(3'd3, 20, "thr2_chk");
    perr = 2'b11;
    cycle();
    wait_state(3'd1, 20, "thr2_rst");
    check("thr2_err", 32'(err), 32'd2);
    check("thr2_retry", 32'(retry), 32'd1);

    // lock timeout twice ends in FAIL
    restart();
    tx = 2'b01; rx = 2'b01; n2 = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (st == 3'd2) n2++;
      if (st == 3'd5) break;
    end
    check("to_wait", 32'(n2), 32'(2 * LOCK));
    check("to_state", 32'(st), 32'd5);
    check("to_retry", 32'(retry), 32'(MAXR));
    check("to_fail", 32'(fail), 32'd1);
    check("to_gtrst", 32'(gt_reset), 32'd1);

    // link loss in UP
    restart();
    tx = 2'b11; rx = 2'b11;
    wait_state(3'd4, 30, "ll_up");
    rx = 2'b01;
    cycle();
    rx = 2'b11;
    check("ll_link", 32'(link_up), 32'd0);
    check("ll_state", 32'(st), 32'd1);
    check("ll_retry", 32'(retry), 32'd1);

    // abort from CHECK with a retry pending
    wait_state(3'd3, 20, "ab_chk");
    en = 1'b0;
    cycle();
    check("ab_state", 32'(st), 32'd0);
    check("ab_retry", 32'(retry), 32'd0);
    en = 1'b1;

    // error on the disabling edge is not counted
    wait_state(3'd4, 30, "se_up");
    en = 1'b0; perr = 2'b11;
    cycle();
    check("se_state", 32'(st), 32'd0);
    check("se_err", 32'(err), 32'd0);

    // randomized episodes
    for (int ep = 0; ep < 20; ep++) begin
      en = 1'b1;
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 250; i++) begin
        case (mode)
          0: begin
            tx = {($urandom_range(0, 199) != 0), ($urandom_range(0, 199) != 0)};
            rx = 2'b11;
            perr = {($urandom_range(0, 149) == 0), ($urandom_range(0, 149) == 0)};
          end
          1: begin
            tx = 2'b11;
            rx = (i < 30) ? 2'b01 : 2'b11;
            perr = {($urandom_range(0, 59) == 0), ($urandom_range(0, 59) == 0)};
          end
          default: begin
            tx = {($urandom_range(0, 29) != 0), ($urandom_range(0, 29) != 0)};
            rx = {($urandom_range(0, 29) != 0), ($urandom_range(0, 29) != 0)};
            perr = {($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0)};
          end
        endcase
        en = ($urandom_range(0, 299) != 0);
        cycle();
      end
      en = 1'b0;
      cycle();
    end

    // asynchronous reset while UP
    restart();
    tx = 2'b11; rx = 2'b11;
    wait_state(3'd4, 30, "ar_up");
    #3 rst_n = 1'b0;
    #1;
    check("ar_state", 32'(st), 32'd0);
    check("ar_gtrst", 32'(gt_reset), 32'd1);
    check("ar_link", 32'(link_up), 32'd0);
    check("ar_fail", 32'(fail), 32'd0);
    check("ar_err", 32'(err), 32'd0);
    check("ar_retry", 32'(retry), 32'd0);
    model_reset();
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // error counter saturation over a long window
    sat_en = 1'b1; sat_err = 2'b11;
    sat_wait(3'd3, 20, "sat_chk");
    check("sat_start", 32'(sat_cnt), 32'd0);
    repeat (10) begin @(posedge clk); #1; end
    check("sat_cnt20", 32'(sat_cnt), 32'd20);
    repeat (33990) begin @(posedge clk); #1; end
    check("sat_mid", 32'(sat_cnt), 32'hFFFF);
    check("sat_st", 32'(sat_st), 32'd3);
    sat_wait(3'd4, 7000, "sat_up");
    check("sat_upcnt", 32'(sat_cnt), 32'hFFFF);
    check("sat_link", 32'(sat_link_up), 32'd1);
    @(posedge clk); #1;
    check("sat_exit", 32'(sat_st), 32'd1);
    check("sat_hold", 32'(sat_cnt), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
